player_anim_engine: RTL and testbench
=====================================

PLAYER_ANIM_ENGINE -- requirements
Module: player_anim_engine

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2, number of player channels (legal 1..8).
REQ-002 SHALL have parameter MOVE_FRAMES, default 24, horizontal-move duration in frame ticks.
REQ-003 SHALL have parameter JUMP_FRAMES, default 16, jump duration in frame ticks (even, >=2).
REQ-004 SHALL have parameter JUMP_H, default 30, jump peak height in pixels.
REQ-005 SHALL have parameters START_X 20, FLAG_X 620, BASE_Y 124, FLAG_TOP_Y 90, SLIDE_FRAMES 20, all unsigned pixel or frame values.
REQ-006 clk  input  1  clock.
REQ-007 rst  input  1  reset; asynchronous, active-high.
REQ-008 frame_tick  input  1  one-cycle pulse per video frame; animation advances only on it.
REQ-009 req_valid  input  NUM_PLAYERS  per-player move request, level; rising edge is the request.
REQ-010 req_x  input  NUM_PLAYERS*10  per-player target x, slice i = bits [10*i+9:10*i].
REQ-011 pos_x, pos_y  output  NUM_PLAYERS*10 each  per-player current sprite coordinates, same slicing.
REQ-012 turn_done  output  NUM_PLAYERS  one-cycle pulse on owning player's bit at animation end.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 active_id  output  3  index of player currently animating; holds last value in IDLE.

Function
REQ-015 SHALL register req_valid and detect rising edges every clk cycle, independent of frame_tick.
REQ-016 SHALL latch each detected edge into a per-player pending bit with target captured from req_x at that cycle; a new edge on an already-pending player overwrites its target.
REQ-017 SHALL never drop a request arriving while busy; it stays pending until served.
REQ-018 SHALL, in IDLE with any pending bit set, grant round-robin starting from (last active_id + 1) mod NUM_PLAYERS, clear that pending bit, load start_x from the player's stored x, and enter MOVING on the same clk edge (no frame_tick needed).
REQ-019 SHALL clamp captured targets above FLAG_X to FLAG_X.
REQ-020 States: IDLE, MOVING, JUMPING, FLAG_SLIDING; counter clears on every state entry.
REQ-021 MOVING: counter increments on frame_tick; x = start_x + (signed(target_x - start_x) * counter) / MOVE_FRAMES with 11-bit signed delta, truncation toward zero, so backward moves are legal; on tick with counter == MOVE_FRAMES-1 store target_x into the player's x and go JUMPING.
REQ-022 JUMPING: y = BASE_Y - (2*JUMP_H*min(counter, JUMP_FRAMES-counter)) / JUMP_FRAMES; on tick with counter == JUMP_FRAMES-1 go FLAG_SLIDING if target_x == FLAG_X else IDLE.
REQ-023 FLAG_SLIDING: y = FLAG_TOP_Y + ((BASE_Y-FLAG_TOP_Y)*counter)/SLIDE_FRAMES; on last tick store BASE_Y and go IDLE.
REQ-024 turn_done SHALL pulse in the cycle after the transition into IDLE, exactly once per served request.
REQ-025 Target equal to current x SHALL still perform full MOVING (stationary) and JUMPING.
REQ-026 Non-active players' pos_x/pos_y SHALL show stored values; the active player's show the computed values while busy.

Reset
REQ-027 Reset SHALL force IDLE, counter 0, pending 0, edge registers 0, active_id NUM_PLAYERS-1 (so player 0 wins first), all stored x = START_X, y = BASE_Y, turn_done 0, busy 0.
REQ-028 Reset asserted mid-animation SHALL abort without turn_done and restore the positions above.

Configuration
REQ-029 Macro PLAYER_ANIM_FLAG_SLIDE_EN: defined -> FLAG_SLIDING behaves as REQ-022/023; undefined -> state absent, JUMPING always returns to IDLE and flag arrival ends like any move.

Structure
REQ-030 Package player_anim_pkg SHALL hold the state enum, the 10-bit coordinate type, and default pixel constants.
REQ-031 Sub-module player_rr_arbiter (pending vector + last grant -> grant index, valid) is the one natural split.

Verification
REQ-032 P0 req_x=100 from reset -> busy next cycle, pos_x reaches 100 after 24 ticks, 16 jump ticks with peak y=94 at counter 8, turn_done[0] pulse.
REQ-033 P1 req_x=700 -> clamped to 620, slide y 90->124 over 20 ticks, turn_done[1]; with macro undefined, no slide, done after jump.
REQ-034 P0 and P1 rising in same cycle -> P0 served first, P1 served immediately after P0's IDLE entry, two turn_done pulses in order.
REQ-035 P0 at 300 requests 100 -> pos_x decreases monotonically to 100, never below 100.
REQ-036 rst pulsed at MOVING counter 10 -> all pos = (20,124), no turn_done, pending cleared.

Source files
------------

// File: rtl/player_anim_pkg.sv
// player_anim_pkg -- shared types and constants for the player animation engine.
//
// Contents:
//   coord_t          10-bit screen coordinate
//   state_t, S_*     animation FSM state encoding (IDLE, MOVING, JUMPING, FLAG_SLIDING)
//   DEF_*            default pixel/frame constants used as parameter defaults
//   clamp_x()        limit a requested target to the flag column
package player_anim_pkg;

   typedef logic [9:0] coord_t;
   typedef logic [1:0] state_t;

   localparam state_t S_IDLE         = 2'd0;
   localparam state_t S_MOVING       = 2'd1;
   localparam state_t S_JUMPING      = 2'd2;
   localparam state_t S_FLAG_SLIDING = 2'd3;

   localparam int DEF_START_X      = 20;
   localparam int DEF_FLAG_X       = 620;
   localparam int DEF_BASE_Y       = 124;
   localparam int DEF_FLAG_TOP_Y   = 90;
   localparam int DEF_MOVE_FRAMES  = 24;
   localparam int DEF_JUMP_FRAMES  = 16;
   localparam int DEF_JUMP_H       = 30;
   localparam int DEF_SLIDE_FRAMES = 20;

   // Targets past the flag are pulled back onto the flag column.
   function automatic coord_t clamp_x(input coord_t x, input coord_t limit);
      return (x > limit) ? limit : x;
   endfunction

endpackage

// File: rtl/player_anim_if.sv
// player_anim_if -- request/position bundle between a game controller and the engine.
//
// Signals (NUM_PLAYERS channels, 10-bit slices at [10*i+9:10*i]):
//   frame_tick  one-cycle pulse per video frame
//   req_valid   per-player move request level (rising edge = request)
//   req_x       per-player target x
//   pos_x/pos_y per-player sprite coordinates
//   turn_done   per-player end-of-animation pulse
//   busy        engine animating
//   active_id   index of the animating (or last animated) player
// Modports: master = controller side, slave = engine side.
interface player_anim_if
   import player_anim_pkg::*;
#(
   parameter int NUM_PLAYERS = 2
);
   logic                      frame_tick;
   logic [NUM_PLAYERS-1:0]    req_valid;
   logic [NUM_PLAYERS*10-1:0] req_x;
   logic [NUM_PLAYERS*10-1:0] pos_x;
   logic [NUM_PLAYERS*10-1:0] pos_y;
   logic [NUM_PLAYERS-1:0]    turn_done;
   logic                      busy;
   logic [2:0]                active_id;

   modport master (
      output frame_tick, req_valid, req_x,
      input  pos_x, pos_y, turn_done, busy, active_id
   );

   modport slave (
      input  frame_tick, req_valid, req_x,
      output pos_x, pos_y, turn_done, busy, active_id
   );
endinterface

// File: rtl/player_rr_arbiter.sv
// player_rr_arbiter -- round-robin pick of the next pending player.
//
// Ports:
//   pending     per-player pending request bits
//   last_grant  index of the previously served player
//   grant_idx   chosen player (valid only when grant_valid)
//   grant_valid any player pending
// Search order starts at last_grant+1 and wraps around.
module player_rr_arbiter
   import player_anim_pkg::*;
#(
   parameter int NUM_PLAYERS = 2
) (
   input  logic [NUM_PLAYERS-1:0] pending,
   input  logic [2:0]             last_grant,
   output logic [2:0]             grant_idx,
   output logic                   grant_valid
);

   // Two passes, each descending so the lowest matching index is the final
   // write: first the wrapped-around range (<= last_grant), then the range
   // above last_grant, which overrides because it comes earlier in the
   // rotation.
   always_comb begin
      grant_idx   = '0;
      grant_valid = 1'b0;
      for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
         if (pending[i] && (i <= int'(last_grant))) begin
            grant_idx   = 3'(i);
            grant_valid = 1'b1;
         end
      end
      for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
         if (pending[i] && (i > int'(last_grant))) begin
            grant_idx   = 3'(i);
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/player_anim_engine.sv
// player_anim_engine -- serialises per-player move requests into a
// move / jump / (optional) flag-slide sprite animation, one player at a time.
//
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  player_anim_if.slave: frame_tick, req_valid, req_x in;
//        pos_x, pos_y, turn_done, busy, active_id out
//
// Build option: define PLAYER_ANIM_FLAG_SLIDE_EN to add the flag slide after a
// jump that lands on FLAG_X; without it every jump returns straight to IDLE.
module player_anim_engine
   import player_anim_pkg::*;
#(
   parameter int NUM_PLAYERS  = 2,
   parameter int MOVE_FRAMES  = DEF_MOVE_FRAMES,
   parameter int JUMP_FRAMES  = DEF_JUMP_FRAMES,
   parameter int JUMP_H       = DEF_JUMP_H,
   parameter int START_X      = DEF_START_X,
   parameter int FLAG_X       = DEF_FLAG_X,
   parameter int BASE_Y       = DEF_BASE_Y,
   parameter int FLAG_TOP_Y   = DEF_FLAG_TOP_Y,
   parameter int SLIDE_FRAMES = DEF_SLIDE_FRAMES
) (
   input  logic         clk,
   input  logic         rst,
   player_anim_if.slave bus
);

   logic [NUM_PLAYERS-1:0] req_valid_q, req_valid_d, rise;
   logic [NUM_PLAYERS-1:0] pending_q, pending_d;
   logic [NUM_PLAYERS-1:0] done_q, done_d;
   logic [NUM_PLAYERS-1:0] active_oh;
   coord_t                 target_q [NUM_PLAYERS];
   coord_t                 target_d [NUM_PLAYERS];
   coord_t                 x_q [NUM_PLAYERS];
   coord_t                 x_d [NUM_PLAYERS];
   state_t                 state_q, state_d;
   logic [15:0]            cnt_q, cnt_d;
   logic [2:0]             active_q, active_d;
   coord_t                 start_x_q, start_x_d;
   coord_t                 goal_q, goal_d;
   logic [2:0]             grant_idx;
   logic                   grant_valid;
   coord_t                 active_x, act_x, act_y;
   logic signed [10:0]     move_delta;
   int                     cnt_i, move_step, jump_m, jump_y, slide_y;
   logic [NUM_PLAYERS*10-1:0] pos_x_o, pos_y_o;

   player_rr_arbiter #(.NUM_PLAYERS(NUM_PLAYERS)) u_arb (
      .pending     (pending_q),
      .last_grant  (active_q),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   // One-hot of the active player plus its stored x; avoids indexing the
   // arrays with a 3-bit id wider than the player count needs.
   always_comb begin
      active_oh = '0;
      active_x  = x_q[0];
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (active_q == 3'(i)) begin
            active_oh[i] = 1'b1;
            active_x     = x_q[i];
         end
      end
   end

   // Request capture, grant and the animation FSM.
   always_comb begin
      req_valid_d = bus.req_valid;
      rise        = bus.req_valid & ~req_valid_q;
      pending_d   = pending_q;
      target_d    = target_q;
      x_d         = x_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      active_d    = active_q;
      start_x_d   = start_x_q;
      goal_d      = goal_q;
      done_d      = '0;

      case (state_q)
         S_IDLE: begin
            if (grant_valid) begin
               state_d  = S_MOVING;
               cnt_d    = '0;
               active_d = grant_idx;
               for (int i = 0; i < NUM_PLAYERS; i++) begin
                  if (grant_idx == 3'(i)) begin
                     pending_d[i] = 1'b0;
                     start_x_d    = x_q[i];
                     goal_d       = target_q[i];
                  end
               end
            end
         end
         S_MOVING: begin
            if (bus.frame_tick) begin
               if (cnt_q == 16'(MOVE_FRAMES - 1)) begin
                  state_d = S_JUMPING;
                  cnt_d   = '0;
                  for (int i = 0; i < NUM_PLAYERS; i++) begin
                     if (active_oh[i]) x_d[i] = goal_q;
                  end
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         S_JUMPING: begin
            if (bus.frame_tick) begin
               if (cnt_q == 16'(JUMP_FRAMES - 1)) begin
                  cnt_d = '0;
`ifdef PLAYER_ANIM_FLAG_SLIDE_EN
                  if (goal_q == 10'(FLAG_X)) begin
                     state_d = S_FLAG_SLIDING;
                  end else begin
                     state_d = S_IDLE;
                     done_d  = active_oh;
                  end
`else
                  state_d = S_IDLE;
                  done_d  = active_oh;
`endif
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
`ifdef PLAYER_ANIM_FLAG_SLIDE_EN
         S_FLAG_SLIDING: begin
            if (bus.frame_tick) begin
               if (cnt_q == 16'(SLIDE_FRAMES - 1)) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
                  done_d  = active_oh;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Applied after the grant so a fresh edge on the player being granted
      // re-arms its pending bit instead of being lost.
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (rise[i]) begin
            pending_d[i] = 1'b1;
            target_d[i]  = clamp_x(bus.req_x[10*i +: 10], 10'(FLAG_X));
         end
      end
   end

   // Sprite position of the active player; the delta is signed so moves to
   // the left interpolate downward and divide with truncation toward zero.
   always_comb begin
      cnt_i      = int'(cnt_q);
      move_delta = $signed({1'b0, goal_q}) - $signed({1'b0, start_x_q});
      move_step  = (int'(move_delta) * cnt_i) / MOVE_FRAMES;
      jump_m     = (cnt_i < (JUMP_FRAMES - cnt_i)) ? cnt_i : (JUMP_FRAMES - cnt_i);
      jump_y     = BASE_Y - (2 * JUMP_H * jump_m) / JUMP_FRAMES;
      slide_y    = FLAG_TOP_Y + ((BASE_Y - FLAG_TOP_Y) * cnt_i) / SLIDE_FRAMES;
      act_x      = active_x;
      act_y      = 10'(BASE_Y);
      case (state_q)
         S_MOVING:       act_x = 10'(int'(start_x_q) + move_step);
         S_JUMPING:      act_y = 10'(jump_y);
         S_FLAG_SLIDING: act_y = 10'(slide_y);
         default:        act_y = 10'(BASE_Y);
      endcase
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if ((state_q != S_IDLE) && active_oh[i]) begin
            pos_x_o[10*i +: 10] = act_x;
            pos_y_o[10*i +: 10] = act_y;
         end else begin
            pos_x_o[10*i +: 10] = x_q[i];
            pos_y_o[10*i +: 10] = 10'(BASE_Y);
         end
      end
   end

   assign bus.pos_x     = pos_x_o;
   assign bus.pos_y     = pos_y_o;
   assign bus.turn_done = done_q;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.active_id = active_q;

   // State registers; reset parks every sprite at the start column and makes
   // player 0 the first round-robin winner.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_valid_q <= '0;
         pending_q   <= '0;
         done_q      <= '0;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         active_q    <= 3'(NUM_PLAYERS - 1);
         start_x_q   <= 10'(START_X);
         goal_q      <= 10'(START_X);
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            target_q[i] <= 10'(START_X);
            x_q[i]      <= 10'(START_X);
         end
      end else begin
         req_valid_q <= req_valid_d;
         pending_q   <= pending_d;
         done_q      <= done_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         active_q    <= active_d;
         start_x_q   <= start_x_d;
         goal_q      <= goal_d;
         target_q    <= target_d;
         x_q         <= x_d;
      end
   end

endmodule

// File: tb/tb_player_anim_engine.sv
// tb_player_anim_engine -- self-checking bench for player_anim_engine.
// Expected sprite paths are generated per request from the animation rules
// into queues and compared frame by frame against the DUT.
module tb_player_anim_engine;

   localparam int NP    = 2;
   localparam int MOVE  = 24;
   localparam int JUMP  = 16;
   localparam int JH    = 30;
   localparam int SX    = 20;
   localparam int FX    = 620;
   localparam int BY    = 124;
   localparam int FTY   = 90;
   localparam int SLIDE = 20;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   player_anim_if #(.NUM_PLAYERS(NP)) bus ();

   player_anim_engine #(.NUM_PLAYERS(NP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;
   int modelX [NP];
   int expX [$];
   int expY [$];
   int obsMinX;

   // One comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Raise one player's request for one cycle with the given target.
   task automatic applyStimulus(input int p, input int x);
      bus.req_valid[p]        = 1'b1;
      bus.req_x[10*p +: 10]   = 10'(x);
      @(negedge clk);
      bus.req_valid[p]        = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulseTick();
      bus.frame_tick = 1'b1;
      @(negedge clk);
      bus.frame_tick = 1'b0;
   endtask

   task automatic waitGrant(input int p, output int lat);
      lat = 0;
      while (!(bus.busy === 1'b1 && int'(bus.active_id) == p) && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      checkOutput($sformatf("grant_p%0d", p),
                  (bus.busy === 1'b1 && int'(bus.active_id) == p) ? 1 : 0, 1);
   endtask

   // Expected (x,y) for each frame of the animation serving player p.
   task automatic buildExpected(input int p, input int reqX);
      int tgt, st, m;
      tgt = (reqX > FX) ? FX : reqX;
      st  = modelX[p];
      expX.delete();
      expY.delete();
      for (int c = 0; c < MOVE; c++) begin
         expX.push_back(st + ((tgt - st) * c) / MOVE);
         expY.push_back(BY);
      end
      for (int c = 0; c < JUMP; c++) begin
         m = (c < JUMP - c) ? c : JUMP - c;
         expX.push_back(tgt);
         expY.push_back(BY - (2 * JH * m) / JUMP);
      end
`ifdef PLAYER_ANIM_FLAG_SLIDE_EN
      if (tgt == FX) begin
         for (int c = 0; c < SLIDE; c++) begin
            expX.push_back(tgt);
            expY.push_back(FTY + ((BY - FTY) * c) / SLIDE);
         end
      end
`endif
      modelX[p] = tgt;
   endtask

   // Walk the expected path; optionally inject two requests for player q
   // (second overwrites the first) partway through.
   task automatic playAnimation(input int p, input int injK, input int q,
                                input int xa, input int xb);
      int ox, oy;
      obsMinX = 1023;
      for (int k = 0; k < expX.size(); k++) begin
         ox = int'(bus.pos_x[10*p +: 10]);
         oy = int'(bus.pos_y[10*p +: 10]);
         if (ox < obsMinX) obsMinX = ox;
         checkOutput($sformatf("p%0d_x_f%0d", p, k), ox, expX[k]);
         checkOutput($sformatf("p%0d_y_f%0d", p, k), oy, expY[k]);
         if (k == 0) begin
            for (int o = 0; o < NP; o++) begin
               if (o != p) begin
                  checkOutput($sformatf("idle_x_p%0d", o), int'(bus.pos_x[10*o +: 10]), modelX[o]);
                  checkOutput($sformatf("idle_y_p%0d", o), int'(bus.pos_y[10*o +: 10]), BY);
               end
            end
         end
         if (k == injK) begin
            applyStimulus(q, xa);
            applyStimulus(q, xb);
         end
         repeat ($urandom_range(0, 1)) @(negedge clk);
         pulseTick();
      end
      checkOutput($sformatf("done_p%0d", p), int'(bus.turn_done), 1 << p);
      checkOutput("busy_idle", int'(bus.busy), 0);
      @(negedge clk);
      checkOutput($sformatf("done_clr_p%0d", p), int'(bus.turn_done[p]), 0);
   endtask

   task automatic serveOne(input int p, input int x);
      int lat;
      applyStimulus(p, x);
      waitGrant(p, lat);
      checkOutput("grant_latency_ok", (lat <= 2) ? 1 : 0, 1);
      buildExpected(p, x);
      playAnimation(p, -1, 0, 0, 0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int lat, p, q, x, xa, xb, sawBusy, sawDone;
      bus.frame_tick = 1'b0;
      bus.req_valid  = '0;
      bus.req_x      = '0;
      rst            = 1'b1;
      repeat (3) @(negedge clk);

      checkOutput("rst_busy", int'(bus.busy), 0);
      checkOutput("rst_done", int'(bus.turn_done), 0);
      checkOutput("rst_active", int'(bus.active_id), NP - 1);
      for (int i = 0; i < NP; i++) begin
         checkOutput($sformatf("rst_x_p%0d", i), int'(bus.pos_x[10*i +: 10]), SX);
         checkOutput($sformatf("rst_y_p%0d", i), int'(bus.pos_y[10*i +: 10]), BY);
         modelX[i] = SX;
      end
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] P0 move to 100, stationary, forward and backward");
      serveOne(0, 100);
      serveOne(0, 100);
      serveOne(0, 300);
      serveOne(0, 100);
      checkOutput("back_min_x", obsMinX, 100);

      $display("[TB] P1 beyond flag");
      serveOne(1, 700);

      $display("[TB] simultaneous requests");
      bus.req_valid         = 2'b11;
      bus.req_x[9:0]        = 10'd200;
      bus.req_x[19:10]      = 10'd450;
      @(negedge clk);
      bus.req_valid         = 2'b00;
      @(negedge clk);
      waitGrant(0, lat);
      buildExpected(0, 200);
      playAnimation(0, -1, 0, 0, 0);
      waitGrant(1, lat);
      checkOutput("p1_follows_immediately", (lat == 0) ? 1 : 0, 1);
      buildExpected(1, 450);
      playAnimation(1, -1, 0, 0, 0);

      $display("[TB] randomized requests with queued overwrite");
      for (int it = 0; it < 5; it++) begin
         p  = int'($urandom_range(0, NP - 1));
         q  = 1 - p;
         x  = int'($urandom_range(0, 1023));
         xa = int'($urandom_range(0, 1023));
         xb = int'($urandom_range(0, 1023));
         applyStimulus(p, x);
         waitGrant(p, lat);
         buildExpected(p, x);
         playAnimation(p, int'($urandom_range(1, 20)), q, xa, xb);
         waitGrant(q, lat);
         buildExpected(q, xb);
         playAnimation(q, -1, 0, 0, 0);
      end

      $display("[TB] reset during move");
      applyStimulus(1, 500);
      waitGrant(1, lat);
      repeat (10) pulseTick();
      applyStimulus(0, 400);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rst2_busy", int'(bus.busy), 0);
      checkOutput("rst2_active", int'(bus.active_id), NP - 1);
      for (int i = 0; i < NP; i++) begin
         checkOutput($sformatf("rst2_x_p%0d", i), int'(bus.pos_x[10*i +: 10]), SX);
         checkOutput($sformatf("rst2_y_p%0d", i), int'(bus.pos_y[10*i +: 10]), BY);
      end
      rst = 1'b0;
      sawBusy = 0;
      sawDone = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.busy !== 1'b0) sawBusy = 1;
         if (bus.turn_done !== '0) sawDone = 1;
      end
      checkOutput("rst2_pending_cleared", sawBusy, 0);
      checkOutput("rst2_no_done", sawDone, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
